// File: rtl/ex_flag_ctx_stack.sv
// EX-stage condition flags with a DEPTH-deep LIFO of saved flag contexts.
// Also registers the branch decision evaluated against the held flags.
module ex_flag_ctx_stack #(
  parameter int FLAG_W = 2,
  parameter int DEPTH  = 4,
  parameter int CC_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic [FLAG_W-1:0]          flags_in,
  input  logic                       cmp,
  input  logic                       int_entry,
  input  logic                       returni,
  input  logic                       br_valid,
  input  logic [CC_W-1:0]            cond,
  input  logic                       err_clr,
  output logic [FLAG_W-1:0]          flags_q,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf,
  output logic                       br_taken
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FLAG_W-1:0] stack_q [DEPTH];
  logic [FLAG_W-1:0] stack_d [DEPTH];
  logic [FLAG_W-1:0] flags_d;
  logic [DW-1:0]     depth_q;
  logic [DW-1:0]     depth_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              unf_q;
  logic              unf_d;
  logic              br_taken_q;
  logic              br_taken_d;
  logic              cond_hit;
  logic              is_z;
  logic              is_n;
  logic              full_w;
  logic              empty_w;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     push_idx;
  logic [DW-1:0]     top_calc;

  assign is_z     = flags_q[0];
  assign is_n     = flags_q[1];
  assign full_w   = (depth_q == DW'(DEPTH));
  assign empty_w  = (depth_q == '0);
  assign top_calc = depth_q - DW'(1);
  assign top_idx  = AW'(top_calc);
  assign push_idx = AW'(depth_q);

  always_comb begin
    cond_hit = 1'b0;
    case (cond[2:0])
      3'd0:    cond_hit = 1'b0;
      3'd1:    cond_hit = 1'b1;
      3'd2:    cond_hit = is_z;
      3'd3:    cond_hit = ~is_z;
      3'd4:    cond_hit = is_n;
      3'd5:    cond_hit = ~is_n;
      3'd6:    cond_hit = ~is_n & ~is_z;
      default: cond_hit = is_n | is_z;
    endcase
  end

  always_comb begin
    flags_d    = flags_q;
    stack_d    = stack_q;
    depth_d    = depth_q;
    ovf_d      = ovf_q & ~err_clr;
    unf_d      = unf_q & ~err_clr;
    br_taken_d = br_taken_q;
    if (!stall) begin
      br_taken_d = br_valid & cond_hit;
      unique case (1'b1)
        (returni & ~int_entry): begin
          if (!empty_w) begin
            flags_d = stack_q[top_idx];
            depth_d = depth_q - DW'(1);
          end else begin
            unf_d = 1'b1;
            if (cmp) flags_d = flags_in;
          end
        end
        (int_entry & ~returni): begin
          if (!full_w) begin
            stack_d[push_idx] = flags_q;
            depth_d = depth_q + DW'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (cmp) flags_d = flags_in;
        end
        (int_entry & returni): begin
          // Nested return-and-reenter: exchange current flags with the top.
          if (!empty_w) begin
            flags_d          = stack_q[top_idx];
            stack_d[top_idx] = flags_q;
          end else begin
            unf_d = 1'b1;
          end
        end
        default: begin
          if (cmp) flags_d = flags_in;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q    <= '0;
      stack_q    <= '{default: '0};
      depth_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      stack_q    <= stack_d;
      depth_q    <= depth_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign depth    = depth_q;
  assign full     = full_w;
  assign empty    = empty_w;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign br_taken = br_taken_q;

endmodule

// File: tb/tb_ex_flag_ctx_stack.sv
// Directed bench for ex_flag_ctx_stack with immediate-assertion checks.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_ex_flag_ctx_stack;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic [1:0] flags_in;
  logic       cmp;
  logic       int_entry;
  logic       returni;
  logic       br_valid;
  logic [2:0] cond;
  logic       err_clr;
  logic [1:0] flags_q;
  logic [2:0] depth;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       unf;
  logic       br_taken;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_flag_ctx_stack #(.FLAG_W(2), .DEPTH(4), .CC_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .flags_in(flags_in), .cmp(cmp),
    .int_entry(int_entry), .returni(returni),
    .br_valid(br_valid), .cond(cond), .err_clr(err_clr),
    .flags_q(flags_q), .depth(depth), .full(full),
    .empty(empty), .ovf(ovf), .unf(unf), .br_taken(br_taken)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall = 0; flags_in = 0; cmp = 0; int_entry = 0;
    returni = 0; br_valid = 0; cond = 0; err_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic state(input string tag, input int f, input int d,
                       input int o, input int u);
    chk({tag, ".flags"}, int'(flags_q), f);
    chk({tag, ".depth"}, int'(depth), d);
    chk({tag, ".ovf"}, int'(ovf), o);
    chk({tag, ".unf"}, int'(unf), u);
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    state("rst", 0, 0, 0, 0);
    chk("rst.empty", int'(empty), 1);
    chk("rst.full", int'(full), 0);
    chk("rst.br", int'(br_taken), 0);

    // Flag load and branch evaluation
    cmp = 1; flags_in = 2'b01; tick();
    chk("t1.flags", int'(flags_q), 1);
    br_valid = 1; cond = 2; tick();
    chk("t1.bz", int'(br_taken), 1);
    br_valid = 1; cond = 3; tick();
    chk("t1.bnz", int'(br_taken), 0);
    br_valid = 1; cond = 2; cmp = 1; flags_in = 2'b00; tick();
    chk("t1.pre_update", int'(br_taken), 1);
    chk("t1.flags00", int'(flags_q), 0);
    br_valid = 1; cond = 6; tick();
    chk("t1.bgt", int'(br_taken), 1);
    br_valid = 1; cond = 0; tick();
    chk("t1.never", int'(br_taken), 0);
    br_valid = 0; cond = 1; tick();
    chk("t1.novalid", int'(br_taken), 0);
    cmp = 1; flags_in = 2'b10; tick();
    br_valid = 1; cond = 4; tick();
    chk("t1.bn", int'(br_taken), 1);
    br_valid = 1; cond = 7; tick();
    chk("t1.ble", int'(br_taken), 1);
    br_valid = 1; cond = 5; tick();
    chk("t1.bnn", int'(br_taken), 0);

    // Nesting
    cmp = 1; flags_in = 2'b01; tick();
    int_entry = 1; tick();
    cmp = 1; flags_in = 2'b10; tick();
    int_entry = 1; tick();
    cmp = 1; flags_in = 2'b11; tick();
    int_entry = 1; tick();
    state("t2.pushed", 3, 3, 0, 0);
    returni = 1; cmp = 1; flags_in = 2'b00; tick();
    state("t2.pop1", 3, 2, 0, 0);
    returni = 1; tick();
    state("t2.pop2", 2, 1, 0, 0);
    returni = 1; tick();
    state("t2.pop3", 1, 0, 0, 0);
    chk("t2.empty", int'(empty), 1);

    // Overflow
    int_entry = 1; cmp = 1; flags_in = 2'b10; tick();
    int_entry = 1; cmp = 1; flags_in = 2'b11; tick();
    int_entry = 1; cmp = 1; flags_in = 2'b00; tick();
    int_entry = 1; cmp = 1; flags_in = 2'b01; tick();
    state("t3.full4", 1, 4, 0, 0);
    chk("t3.full", int'(full), 1);
    int_entry = 1; cmp = 1; flags_in = 2'b10; tick();
    state("t3.ovf", 2, 4, 1, 0);
    returni = 1; tick();
    state("t3.pop1", 0, 3, 1, 0);
    chk("t3.notfull", int'(full), 0);
    returni = 1; tick();
    state("t3.pop2", 3, 2, 1, 0);
    returni = 1; tick();
    state("t3.pop3", 2, 1, 1, 0);
    returni = 1; tick();
    state("t3.pop4", 1, 0, 1, 0);
    err_clr = 1; tick();
    state("t3.clr", 1, 0, 0, 0);

    // Underflow and collisions
    returni = 1; tick();
    state("t4.unf", 1, 0, 0, 1);
    returni = 1; err_clr = 1; tick();
    state("t4.err_wins", 1, 0, 0, 1);
    err_clr = 1; tick();
    state("t4.clr", 1, 0, 0, 0);
    returni = 1; cmp = 1; flags_in = 2'b11; tick();
    state("t4.unf_cmp", 3, 0, 0, 1);
    err_clr = 1; cmp = 1; flags_in = 2'b10; tick();
    int_entry = 1; cmp = 1; flags_in = 2'b01; tick();
    state("t4.setup", 1, 1, 0, 0);
    int_entry = 1; returni = 1; cmp = 1; flags_in = 2'b11; tick();
    state("t4.swap", 2, 1, 0, 0);
    returni = 1; tick();
    state("t4.newtop", 1, 0, 0, 0);
    int_entry = 1; returni = 1; cmp = 1; flags_in = 2'b11; tick();
    state("t4.swap_empty", 1, 0, 0, 1);
    err_clr = 1; tick();

    // Stall
    cmp = 1; flags_in = 2'b10; tick();
    int_entry = 1; tick();
    br_valid = 1; cond = 1; tick();
    chk("t5.br_pre", int'(br_taken), 1);
    stall = 1; cmp = 1; flags_in = 2'b01; int_entry = 1;
    br_valid = 1; cond = 0; tick();
    state("t5.stall_push", 2, 1, 0, 0);
    chk("t5.br_held", int'(br_taken), 1);
    stall = 1; returni = 1; tick();
    state("t5.stall_pop", 2, 1, 0, 0);
    returni = 1; tick();
    state("t5.pop", 2, 0, 0, 0);
    chk("t5.br_clr", int'(br_taken), 0);
    returni = 1; tick();
    state("t5.unf", 2, 0, 0, 1);
    stall = 1; err_clr = 1; tick();
    state("t5.stall_clr", 2, 0, 0, 0);
    stall = 1; returni = 1; tick();
    state("t5.stall_nounf", 2, 0, 0, 0);

    // Reset mid-operation
    repeat (5) begin
      int_entry = 1; tick();
    end
    returni = 1; br_valid = 1; cond = 1; tick();
    state("t6.pre", 2, 3, 1, 0);
    chk("t6.br_pre", int'(br_taken), 1);
    rst_n = 0; tick();
    rst_n = 1;
    state("t6.rst", 0, 0, 0, 0);
    chk("t6.empty", int'(empty), 1);
    chk("t6.full", int'(full), 0);
    chk("t6.br", int'(br_taken), 0);
    returni = 1; tick();
    state("t6.post_unf", 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
